// File: rtl/aggTypes.sv
// Shared types for the distinct-engine arbiter slice.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
//
// Contents: requester count, tag depth, requester-id type, dist_t beat,
// issue-side FSM state encoding, round-robin pointer advance.
package aggTypes;

  localparam int KEY_W          = 32;
  localparam int N_REQ_DIST     = 4;
  localparam int DIST_TAG_DEPTH = 32;
  // Wide enough for the largest supported requester count (8).
  localparam int REQ_ID_W       = 3;

  typedef logic [REQ_ID_W-1:0] req_id_t;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic             last;
    logic             hit;
  } dist_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // Next round-robin start point after requester id finishes a packet.
  function automatic req_id_t next_rr(input req_id_t id, input int n_req);
    if (int'(id) == n_req - 1) begin
      return '0;
    end
    return id + req_id_t'(1);
  endfunction

endpackage

// File: rtl/metaIntf.sv
// Valid/ready stream carrying one dist_t beat per handshake.
// Latency: none (wires only).
// Backpressure: beat transfers when valid and ready are both high.
//
// Modports: m = producer (drives valid, data), s = consumer (drives ready).
interface metaIntf;
  import aggTypes::*;

  logic  valid;
  logic  ready;
  dist_t data;

  modport m (output valid, output data, input ready);
  modport s (input valid, input data, output ready);

endinterface

// File: rtl/distinct_tag_fifo.sv
// Synchronous FIFO of requester ids, one entry per beat in flight in the engine.
// Latency: head valid the cycle after the first push; count updates on the clock.
// Backpressure: push ignored when full, pop ignored when empty.
//
// Ports: aclk/areset (sync, active-high); push/push_id write; pop retires head;
//        head, full, empty, count report state.
module distinct_tag_fifo
  import aggTypes::*;
#(
  parameter  int DEPTH = DIST_TAG_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          push,
  input  req_id_t       push_id,
  input  logic          pop,
  output req_id_t       head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  req_id_t       mem [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + AW'(1);
      end
      // Simultaneous push and pop leave the count unchanged.
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) begin
      mem[wr_q] <= push_id;
    end
  end

endmodule

// File: rtl/distinct_arbiter.sv
// Shares one in-order distinct engine among N_REQ requester streams, packet-locked round robin.
// Latency: one bubble cycle per packet for grant, then zero-latency issue; responses pass straight through.
// Backpressure: issue stalls on engine ready or full tag store; a stalled result only stalls s_dist.
//
// Ports: aclk/areset (sync, active-high); s_meta[] requester keys in; m_meta[] results out;
//        m_dist issue to engine; s_dist results from engine; busy; err (sticky orphan response).
module distinct_arbiter
  import aggTypes::*;
#(
  parameter int N_REQ     = N_REQ_DIST,
  parameter int TAG_DEPTH = DIST_TAG_DEPTH
) (
  input  logic aclk,
  input  logic areset,
  metaIntf.s   s_meta [N_REQ],
  metaIntf.m   m_meta [N_REQ],
  metaIntf.m   m_dist,
  metaIntf.s   s_dist,
  output logic busy,
  output logic err
);

  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  arb_state_t state_q, state_d;
  req_id_t    rr_q, rr_d;
  req_id_t    gnt_q, gnt_d;

  logic [N_REQ-1:0] req_vld;
  logic [N_REQ-1:0] req_rdy;
  dist_t            req_dat [N_REQ];
  logic [N_REQ-1:0] out_vld;
  logic [N_REQ-1:0] out_rdy;

  logic       iss_vld;
  dist_t      iss_dat;
  logic       rsp_rdy;
  logic       err_set;

  logic             tag_push;
  logic             tag_pop;
  logic             tag_full;
  logic             tag_empty;
  req_id_t          tag_head;
  logic [CNT_W-1:0] tag_count;

  // Flatten the interface arrays so the grant and tag head can index them.
  for (genvar g = 0; g < N_REQ; g++) begin : g_io
    assign req_vld[g]       = s_meta[g].valid;
    assign req_dat[g]       = s_meta[g].data;
    assign s_meta[g].ready  = req_rdy[g];
    assign m_meta[g].valid  = out_vld[g];
    assign m_meta[g].data   = s_dist.data;
    assign out_rdy[g]       = m_meta[g].ready;
  end

  assign m_dist.valid = iss_vld;
  assign m_dist.data  = iss_dat;
  assign s_dist.ready = rsp_rdy;

  // Issue side: pick a requester in IDLE, then stream its packet while LOCKED.
  always_comb begin
    logic    sel_found;
    req_id_t sel_id;
    logic    gnt_vld;
    dist_t   gnt_dat;

    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    req_rdy   = '0;
    iss_vld   = 1'b0;
    iss_dat   = '0;
    tag_push  = 1'b0;
    sel_found = 1'b0;
    sel_id    = '0;
    gnt_vld   = 1'b0;
    gnt_dat   = '0;

    // Rotated priority search starting at rr_q.
    for (int i = 0; i < N_REQ; i++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!sel_found && req_vld[j] && ((int'(rr_q) + i) % N_REQ == j)) begin
          sel_found = 1'b1;
          sel_id    = req_id_t'(j);
        end
      end
    end

    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q == req_id_t'(i)) begin
        gnt_vld = req_vld[i];
        gnt_dat = req_dat[i];
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          gnt_d   = sel_id;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        for (int i = 0; i < N_REQ; i++) begin
          if (gnt_q == req_id_t'(i)) begin
            req_rdy[i] = m_dist.ready && !tag_full;
          end
        end
        iss_vld  = gnt_vld && !tag_full;
        iss_dat  = gnt_dat;
        tag_push = iss_vld && m_dist.ready;
        // Grant is released only on the accepted last beat.
        if (tag_push && gnt_dat.last) begin
          rr_d    = next_rr(gnt_q, N_REQ);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (areset) begin
      req_rdy  = '0;
      iss_vld  = 1'b0;
      tag_push = 1'b0;
    end
  end

  // Response side: the tag head names the requester owning the next engine result.
  always_comb begin
    out_vld = '0;
    rsp_rdy = 1'b0;
    tag_pop = 1'b0;
    err_set = 1'b0;

    if (!tag_empty) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (tag_head == req_id_t'(i)) begin
          out_vld[i] = s_dist.valid;
          rsp_rdy    = out_rdy[i];
        end
      end
      tag_pop = s_dist.valid && rsp_rdy;
    end else begin
      // Nothing outstanding: swallow any beat and flag it.
      rsp_rdy = 1'b1;
      err_set = s_dist.valid;
    end

    if (areset) begin
      out_vld = '0;
      rsp_rdy = 1'b0;
      tag_pop = 1'b0;
      err_set = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

  assign busy = !areset && ((state_q == ST_LOCKED) || (tag_count != '0));

  distinct_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tags (
    .aclk    (aclk),
    .areset  (areset),
    .push    (tag_push),
    .push_id (gnt_q),
    .pop     (tag_pop),
    .head    (tag_head),
    .full    (tag_full),
    .empty   (tag_empty),
    .count   (tag_count)
  );

endmodule

// File: tb/tb_distinct_arbiter.sv
// Self-checking bench for distinct_arbiter: requester sources, an in-order engine model
// and a scoreboard of expected per-requester results.
`timescale 1ns/1ps
module tb_distinct_arbiter;
  import aggTypes::*;

  localparam int N     = 4;
  localparam int DEPTH = 32;

  typedef struct packed {
    logic [2:0] req;
    dist_t      d;
  } exp_t;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  metaIntf s_meta [N] ();
  metaIntf m_meta [N] ();
  metaIntf m_dist ();
  metaIntf s_dist ();
  logic busy;
  logic err;

  distinct_arbiter #(
    .N_REQ     (N),
    .TAG_DEPTH (DEPTH)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .s_meta (s_meta),
    .m_meta (m_meta),
    .m_dist (m_dist),
    .s_dist (s_dist),
    .busy   (busy),
    .err    (err)
  );

  logic [N-1:0] s_vld, s_rdy, m_vld, m_rdy;
  dist_t        s_dat [N];
  dist_t        m_dat [N];
  logic         dist_vld, dist_rdy, rsp_vld, rsp_rdy;
  dist_t        dist_dat, rsp_dat;

  for (genvar g = 0; g < N; g++) begin : g_glue
    assign s_meta[g].valid = s_vld[g];
    assign s_meta[g].data  = s_dat[g];
    assign s_rdy[g]        = s_meta[g].ready;
    assign m_vld[g]        = m_meta[g].valid;
    assign m_dat[g]        = m_meta[g].data;
    assign m_meta[g].ready = m_rdy[g];
  end
  assign dist_vld     = m_dist.valid;
  assign dist_dat     = m_dist.data;
  assign m_dist.ready = dist_rdy;
  assign s_dist.valid = rsp_vld;
  assign s_dist.data  = rsp_dat;
  assign rsp_rdy      = s_dist.ready;

  // Models and bookkeeping
  dist_t        src_q [N][$];
  logic [N-1:0] src_en;
  dist_t        eng_q [$];
  int           eng_budget;
  logic         spur;
  dist_t        spur_dat;
  exp_t         sb [$];
  int           log_req [$];
  int           log_cyc [$];
  int           cyc;
  int           n_chk, n_pass, n_fail;
  logic         lock_watch;
  int           lock_viol;
  logic [31:0]  key_ctr;

  // Values sampled mid-cycle in the most recent step
  logic [N-1:0] s_rdy_s, m_vld_s;
  logic         rsp_rdy_s, rsp_vld_s, dist_vld_s, busy_s, err_s;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int r, input int nbeats);
    dist_t b;
    for (int k = 0; k < nbeats; k++) begin
      b.key  = key_ctr;
      b.last = (k == nbeats - 1);
      b.hit  = 1'b0;
      key_ctr = key_ctr + 32'd1;
      src_q[r].push_back(b);
    end
  endtask

  function automatic int pending();
    int p;
    p = eng_q.size();
    for (int r = 0; r < N; r++) p += src_q[r].size();
    return p;
  endfunction

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      s_vld[r] = src_en[r] && (src_q[r].size() > 0);
      s_dat[r] = '0;
      if (src_q[r].size() > 0) s_dat[r] = src_q[r][0];
    end
    if (spur) begin
      rsp_vld = 1'b1;
      rsp_dat = spur_dat;
    end else begin
      rsp_vld = (eng_q.size() > 0) && (eng_budget != 0);
      rsp_dat = '0;
      if (eng_q.size() > 0) begin
        rsp_dat     = eng_q[0];
        rsp_dat.hit = eng_q[0].key[0];
      end
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, update models at posedge.
  task automatic step();
    logic [N-1:0] ihs, ohs;
    logic         dhs, rhs;
    dist_t        dd;
    dist_t        md [N];
    exp_t         e, o;
    drive();
    #1;
    ihs = s_vld & s_rdy;
    ohs = m_vld & m_rdy;
    dhs = dist_vld & dist_rdy;
    rhs = rsp_vld & rsp_rdy;
    dd  = dist_dat;
    for (int r = 0; r < N; r++) md[r] = m_dat[r];
    s_rdy_s = s_rdy; m_vld_s = m_vld; rsp_rdy_s = rsp_rdy; rsp_vld_s = rsp_vld;
    dist_vld_s = dist_vld; busy_s = busy; err_s = err;
    if (lock_watch && s_rdy[1]) lock_viol++;
    @(posedge aclk);
    cyc++;
    if (dhs || ihs != '0) chk("issue_onehot", $countones(ihs), dhs ? 1 : 0);
    if (dhs) begin
      for (int r = 0; r < N; r++) begin
        if (ihs[r] && src_q[r].size() > 0) begin
          chk("issue_data", dd, src_q[r][0]);
          e.req   = 3'(r);
          e.d     = src_q[r][0];
          e.d.hit = src_q[r][0].key[0];
          sb.push_back(e);
          eng_q.push_back(dd);
          log_req.push_back(r);
          log_cyc.push_back(cyc);
          void'(src_q[r].pop_front());
        end
      end
    end
    if (rhs && !spur && eng_q.size() > 0) begin
      void'(eng_q.pop_front());
      if (eng_budget > 0) eng_budget--;
    end
    for (int r = 0; r < N; r++) begin
      if (ohs[r]) begin
        chk("out_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          o.req = 3'(r);
          o.d   = md[r];
          chk("out_beat", o, sb.pop_front());
        end
      end
    end
    @(negedge aclk);
  endtask

  task automatic drain(input string tag, input int max);
    int n;
    n = 0;
    while ((sb.size() > 0 || pending() > 0) && n < max) begin
      step();
      n++;
    end
    chk(tag, sb.size() + pending(), 0);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    for (int r = 0; r < N; r++) src_q[r].delete();
    eng_q.delete(); sb.delete(); log_req.delete(); log_cyc.delete();
    spur = 1'b0; eng_budget = -1; m_rdy = '1; dist_rdy = 1'b1; src_en = '1;
    lock_watch = 1'b0; lock_viol = 0;
    repeat (2) step();
    areset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start, idx, n;
    n_chk = 0; n_pass = 0; n_fail = 0; cyc = 0; key_ctr = 32'h100;
    spur_dat = '0; spur_dat.key = 32'hdead_beef; spur_dat.last = 1'b1;

    // Reset: outputs quiet even with valid requesters and engine.
    do_reset();
    areset = 1'b1;
    load(0, 1);
    spur = 1'b1;
    step();
    chk("rst_s_rdy", s_rdy_s, 0);
    chk("rst_dist_vld", dist_vld_s, 0);
    chk("rst_rsp_rdy", rsp_rdy_s, 0);
    chk("rst_m_vld", m_vld_s, 0);
    chk("rst_busy", busy_s, 0);
    chk("rst_err", err_s, 0);
    spur = 1'b0;
    src_q[0].delete();
    areset = 1'b0;
    step();
    chk("post_rst_busy", busy_s, 0);
    chk("post_rst_err", err_s, 0);

    // Single 3-beat packet from requester 2.
    do_reset();
    load(2, 3);
    start = cyc;
    step();
    chk("single_bubble", log_req.size(), 0);
    step();
    chk("single_first_issue", log_cyc.size() > 0 ? log_cyc[0] - start : -1, 2);
    chk("single_busy", busy_s, 1);
    drain("single_drain", 40);
    step();
    chk("single_busy_fall", busy_s, 0);
    chk("single_count", log_req.size(), 3);
    // rr_ptr now 3: requester 3 beats requester 0.
    idx = log_req.size();
    load(0, 1);
    load(3, 1);
    drain("rr_drain", 40);
    chk("rr_first", log_req.size() > idx ? log_req[idx] : -1, 3);
    chk("rr_second", log_req.size() > idx + 1 ? log_req[idx + 1] : -1, 0);

    // Fairness: all requesters with back-to-back single-beat packets.
    do_reset();
    for (int k = 0; k < 3; k++) for (int r = 0; r < N; r++) load(r, 1);
    drain("fair_drain", 100);
    chk("fair_count", log_req.size(), 12);
    for (int k = 0; k < log_req.size(); k++) begin
      chk("fair_order", log_req[k], k % N);
      if (k > 0) chk("fair_gap", log_cyc[k] - log_cyc[k - 1], 2);
    end

    // Packet lock: requester 1 waits out requester 0's 5-beat packet.
    do_reset();
    load(0, 5);
    load(1, 1);
    lock_watch = 1'b1;
    n = 0;
    while (log_req.size() < 5 && n < 30) begin step(); n++; end
    lock_watch = 1'b0;
    chk("lock_no_r1_ready", lock_viol, 0);
    drain("lock_drain", 40);
    chk("lock_count", log_req.size(), 6);
    if (log_req.size() == 6) begin
      chk("lock_beat5_owner", log_req[4], 0);
      chk("lock_r1_after", log_req[5], 1);
      chk("lock_gap", log_cyc[5] - log_cyc[4], 2);
    end

    // Tag store full: engine silent, 34-beat packet stalls at 32.
    do_reset();
    eng_budget = 0;
    load(0, 34);
    n = 0;
    while (log_req.size() < 32 && n < 80) begin step(); n++; end
    repeat (5) step();
    chk("full_issued", log_req.size(), 32);
    chk("full_s_rdy", s_rdy_s[0], 0);
    chk("full_dist_vld", dist_vld_s, 0);
    chk("full_busy", busy_s, 1);
    eng_budget = 1;
    repeat (6) step();
    chk("full_one_more", log_req.size(), 33);
    chk("full_still_stalled", dist_vld_s, 0);
    eng_budget = -1;
    drain("full_drain", 200);
    chk("full_total", log_req.size(), 34);

    // Result backpressure on requester 1 while others keep issuing.
    do_reset();
    m_rdy[1] = 1'b0;
    load(1, 1);
    load(2, 1);
    load(3, 1);
    repeat (12) step();
    chk("bp_issued", log_req.size(), 3);
    chk("bp_rsp_vld", rsp_vld_s, 1);
    chk("bp_rsp_rdy", rsp_rdy_s, 0);
    chk("bp_m_vld", m_vld_s, 4'b0010);
    chk("bp_held", sb.size(), 3);
    m_rdy[1] = 1'b1;
    drain("bp_drain", 40);
    chk("bp_no_err", err_s, 0);

    // Orphan response with nothing outstanding.
    do_reset();
    spur = 1'b1;
    step();
    chk("spur_rdy", rsp_rdy_s, 1);
    chk("spur_m_vld", m_vld_s, 0);
    spur = 1'b0;
    step();
    chk("spur_err", err_s, 1);
    repeat (5) step();
    chk("spur_err_held", err_s, 1);
    chk("spur_no_output", sb.size(), 0);
    areset = 1'b1;
    step();
    areset = 1'b0;
    step();
    chk("spur_err_cleared", err_s, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/distinct_arbiter.md
DISTINCT_ARBITER -- requirements
Module: distinct_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requester streams sharing one distinct engine (2..8).
REQ-002 SHALL have parameter TAG_DEPTH, default 32: maximum items in flight inside the engine (power of two).
REQ-003 SHALL have port aclk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have port areset, input, 1 bit: reset, synchronous to aclk and active-high.
REQ-005 SHALL have port s_meta[N_REQ], metaIntf.s, dist_t: per-requester key streams (key, last).
REQ-006 SHALL have port m_meta[N_REQ], metaIntf.m, dist_t: per-requester results (key, last, hit).
REQ-007 SHALL have port m_dist, metaIntf.m, dist_t: issue stream to the distinct engine.
REQ-008 SHALL have port s_dist, metaIntf.s, dist_t: in-order result stream from the distinct engine.
REQ-009 SHALL have port busy, output, 1 bit: high while the state is LOCKED or any tag is outstanding.
REQ-010 SHALL have port err, output, 1 bit: sticky flag for a response that arrives with no outstanding tag.

Function
REQ-011 SHALL use a 2-state FSM for the issue side: IDLE and LOCKED.
REQ-012 In IDLE, SHALL select the first requester with valid=1, searching from rr_ptr upward and wrapping modulo N_REQ.
REQ-013 On a selection, SHALL register the winner as gnt_id and enter LOCKED on the next cycle, giving exactly one bubble cycle per packet.
REQ-014 In IDLE, SHALL drive all s_meta.ready and m_dist.valid to 0.
REQ-015 In LOCKED, SHALL set s_meta[gnt_id].ready = m_dist.ready & !tag_full; every other s_meta.ready SHALL be 0.
REQ-016 In LOCKED, SHALL set m_dist.valid = s_meta[gnt_id].valid & !tag_full, with the data passed through combinationally (zero-latency issue).
REQ-017 On every beat accepted on m_dist, SHALL push gnt_id into the tag FIFO.
REQ-018 When an accepted beat has last=1, SHALL set rr_ptr = (gnt_id+1) mod N_REQ and return to IDLE; the grant SHALL never change mid-packet.
REQ-019 SHALL assert tag_full when the outstanding count equals TAG_DEPTH; a push SHALL be allowed only when tag_full=0 at the start of the cycle.
REQ-020 Response routing: with the tag FIFO not empty and head = h, SHALL set m_meta[h].valid = s_dist.valid and s_dist.ready = m_meta[h].ready; every other m_meta.valid SHALL be 0.
REQ-021 On s_dist handshake, SHALL pop the tag head and forward key/last/hit unmodified.
REQ-022 When a push and a pop occur in the same cycle, the outstanding count SHALL be unchanged; the count width SHALL be clog2(TAG_DEPTH)+1.
REQ-023 With the tag FIFO empty, SHALL hold s_dist.ready = 1 (drain) and set err = 1 on any s_dist.valid; the beat SHALL be discarded.
REQ-024 Backpressure on m_meta[h] SHALL stall only the response side; issue SHALL continue until tag_full.

Reset
REQ-025 While areset=1, SHALL hold state=IDLE, rr_ptr=0, gnt_id=0, tag FIFO empty, count=0, err=0.
REQ-026 While areset=1, SHALL drive all ready and valid outputs to 0 and busy=0.
REQ-027 Reset mid-packet SHALL drop the grant and all outstanding tags; the engine is reset by the same signal.

Structure
REQ-028 N_REQ_DIST, DIST_TAG_DEPTH and the requester-id typedef SHALL live in aggTypes alongside dist_t.
REQ-029 The tag store SHALL be one sub-module, distinct_tag_fifo: synchronous FIFO of requester ids with full, empty and count outputs.

Verification
REQ-030 Single packet: requester 2 sends 3 keys, last on key 3, engine echoes each with hit=0 -> m_meta[2] receives 3 beats in order; rr_ptr = 3; busy falls after the final pop.
REQ-031 Fairness: all 4 requesters continuously send 1-beat packets -> grant order 0,1,2,3,0,... with exactly one idle cycle between packets.
REQ-032 Packet lock: requester 0 sends a 5-beat packet while requester 1 is valid -> requester 1 sees no ready until the cycle after beat 5's last is accepted.
REQ-033 Full: engine holds s_dist.valid=0 until 32 items are issued -> the 33rd beat stalls (ready=0); one pop re-enables exactly one push.
REQ-034 Response backpressure: m_meta[1].ready=0 for 10 cycles with head=1 -> s_dist.ready=0, no beat is lost, issue continues for other tags.
REQ-035 Spurious response: s_dist.valid=1 with the FIFO empty -> beat consumed, err=1 held until areset.
